sliding_window_buffer: RTL
==========================

Name: sliding_window_buffer

Overview:
- Streaming stage directly upstream of kernel_convolution.
- Accepts one signed pixel per cycle in raster order.
- Stores the previous KERNEL_SIZE-1 image lines and presents a full KERNEL_SIZE x KERNEL_SIZE pixel window each cycle in the exact array shape kernel_convolution consumes on its buffer_in port.
- Emits valid-window (no-padding) positions only, tagged with image coordinates.

Parameters:
- KERNEL_SIZE, 3, window edge length; odd, >= 2.
- WORD_SIZE, 8, bits per signed pixel.
- IMAGE_WIDTH, 640, pixels per line; must be >= KERNEL_SIZE.
- IMAGE_HEIGHT, 480, lines per frame; must be >= KERNEL_SIZE.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  in_data is a valid pixel this cycle; no backpressure.
- in_sof  in  1  qualified by in_valid: this pixel is (row 0, col 0) of a new frame.
- in_data  in  WORD_SIZE signed  pixel value.
- window  out  [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0] x WORD_SIZE signed  window[r][c]: r=0 is the oldest line, c=0 is the oldest column.
- window_valid  out  1  window is a complete, in-frame window.
- out_row  out  $clog2(IMAGE_HEIGHT)  row of window's bottom-right pixel (newest).
- out_col  out  $clog2(IMAGE_WIDTH)  column of window's bottom-right pixel.

Behaviour:
- Reset (reset_n low at a clk edge):
  - col/row counters go to 0.
  - All window registers go to 0.
  - window_valid, out_row and out_col go to 0.
  - Line-buffer RAM is not cleared; its contents are don't-care because validity gating hides them.
- Reset mid-frame:
  - Discards the partial frame.
  - The next in_valid pixel is treated as (0,0) whether or not in_sof is set.
- Per accepted pixel (in_valid=1):
  - Position (row, col) is taken from the counters; if in_sof=1 the position is forced to (0,0).
  - Line buffer k (k=0..K-2) returns the pixel at the same col from k+1 lines earlier and stores the pixel from k lines earlier.
  - Column-shift: each window row shifts left by one (c <- c+1).
  - New rightmost column: window[K-1][K-1] <- in_data; window[K-2-k][K-1] <- line buffer k output.
  - Counters advance: col+1; at col=IMAGE_WIDTH-1, col wraps to 0 and row increments; at row=IMAGE_HEIGHT-1 with col wrap, row wraps to 0 (implicit new frame).
- Latency: window, window_valid, out_row and out_col are registered, valid the cycle after the accepting edge (1-cycle latency).
- window_valid=1 iff the previous cycle accepted a pixel with row >= KERNEL_SIZE-1 and col >= KERNEL_SIZE-1.
- Windows never straddle a line boundary: col gating guarantees this because columns 0..K-2 of a line are suppressed.
- Valid windows per frame = (IMAGE_WIDTH-K+1)*(IMAGE_HEIGHT-K+1).
- Idle (in_valid=0):
  - window, out_row and out_col hold.
  - window_valid=0 next cycle.
  - Counters and line buffers are unchanged.
  - Gaps are allowed anywhere, including mid-line.
- in_sof on a pixel that is already (0,0): no effect.
- in_sof mid-frame:
  - Restarts at (0,0).
  - The next KERNEL_SIZE-1 rows produce no valid output (stale lines hidden).
- in_sof with in_valid=0: ignored.
- No arithmetic on pixel data: values pass through bit-exact, sign preserved.

Decomposition:
- Package conv_pkg:
  - KERNEL_SIZE and WORD_SIZE defaults.
  - typedef logic signed [WORD_SIZE-1:0] pixel_t.
  - window_t typedef (pixel_t [K-1:0][K-1:0]).
  - Shared with kernel_convolution.
- Sub-module line_buffer:
  - Parameters DEPTH=IMAGE_WIDTH and WIDTH=WORD_SIZE.
  - Single-port read-before-write RAM indexed by col, enabled by in_valid.
  - Combinational-read or registered-read variant, with the window shift aligned to match.
  - KERNEL_SIZE-1 instances chained; instance k feeds k+1.

Test Plan (K=3, WORD_SIZE=8, IMAGE_WIDTH=4, IMAGE_HEIGHT=4, pixel = row*4+col, in_sof on first pixel):
- Continuous frame: first window_valid the cycle after pixel 10 is accepted.
  - window = {{0,1,2},{4,5,6},{8,9,10}}, out_row=2, out_col=2.
  - Next: {{1,2,3},{5,6,7},{9,10,11}}.
  - Exactly 4 valid windows per frame.
- Line boundary: pixels 12 and 13 (row 3, col 0/1) produce window_valid=0.
  - Pixel 14 produces {{4,5,6},{8,9,10},{12,13,14}}, out_row=3, out_col=2.
- Bubbles: insert in_valid=0 gaps of 1–3 cycles between every pixel.
  - Identical window sequence; window holds and window_valid=0 during gaps.
- Negative data: pixel = -(row*4+col) (signed).
  - First window = {{0,-1,-2},{-4,-5,-6},{-8,-9,-10}} bit-exact (e.g. -10 = 8'hF6).
- Mid-frame in_sof: after row 1, col 2, assert in_sof with new frame data (pixel = 100 + row*4+col).
  - No valid output until new pixel 110.
  - Window = {{100,101,102},{104,105,106},{108,109,110}}, with no stale data.
- Reset mid-frame: reset_n=0 for 2 cycles during row 2.
  - All outputs 0 the next cycle.
  - The following frame (sent without in_sof) reproduces scenario 1 exactly.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared pixel/window types for the convolution pipeline (sliding_window_buffer
// feeds kernel_convolution with window_t-shaped data).
package conv_pkg;

  localparam int unsigned KERNEL_SIZE = 3;
  localparam int unsigned WORD_SIZE   = 8;

  typedef logic signed [WORD_SIZE-1:0]           pixel_t;
  typedef pixel_t [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0] window_t;

  // True when a KxK window ending at (row, col) lies fully inside the frame.
  function automatic logic pos_in_window(input int unsigned row,
                                         input int unsigned col,
                                         input int unsigned k);
    return (row >= k - 1) && (col >= k - 1);
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One image line of storage: single-port, read-before-write RAM indexed by column.
// Read is combinational so the previous line's pixel lines up with the incoming one.
module line_buffer #(
  parameter int unsigned DEPTH = 640,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     en_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o
);
  import conv_pkg::*;

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (en_i) begin
      mem_q[addr_i] <= din_i;
    end
  end

  assign dout_o = mem_q[addr_i];

endmodule

// File: rtl/sliding_window_buffer.sv
// Raster-order pixel stream in, KxK in-frame window out (1-cycle latency),
// tagged with the row/col of the newest pixel.
module sliding_window_buffer #(
  parameter int unsigned KERNEL_SIZE  = conv_pkg::KERNEL_SIZE,
  parameter int unsigned WORD_SIZE    = conv_pkg::WORD_SIZE,
  parameter int unsigned IMAGE_WIDTH  = 640,
  parameter int unsigned IMAGE_HEIGHT = 480
) (
  input  logic                                                  clk,
  input  logic                                                  reset_n,
  input  logic                                                  in_valid,
  input  logic                                                  in_sof,
  input  logic signed [WORD_SIZE-1:0]                           in_data,
  output logic signed [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][WORD_SIZE-1:0] window,
  output logic                                                  window_valid,
  output logic [$clog2(IMAGE_HEIGHT)-1:0]                       out_row,
  output logic [$clog2(IMAGE_WIDTH)-1:0]                        out_col
);
  import conv_pkg::*;

  localparam int unsigned COL_W = $clog2(IMAGE_WIDTH);
  localparam int unsigned ROW_W = $clog2(IMAGE_HEIGHT);
  localparam int unsigned NLB   = KERNEL_SIZE - 1;

  logic [COL_W-1:0] col_q, col_d, pos_col;
  logic [ROW_W-1:0] row_q, row_d, pos_row;
  logic [COL_W-1:0] out_col_q;
  logic [ROW_W-1:0] out_row_q;
  logic             valid_q, valid_d;
  logic signed [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][WORD_SIZE-1:0] win_q, win_d;

  logic [WORD_SIZE-1:0] lb_din  [NLB];
  logic [WORD_SIZE-1:0] lb_dout [NLB];

  // in_sof overrides the counters so the pixel itself is placed at (0,0).
  always_comb begin
    pos_col = in_sof ? '0 : col_q;
    pos_row = in_sof ? '0 : row_q;
    col_d   = col_q;
    row_d   = row_q;
    if (in_valid) begin
      if (pos_col == COL_W'(IMAGE_WIDTH - 1)) begin
        col_d = '0;
        row_d = (pos_row == ROW_W'(IMAGE_HEIGHT - 1)) ? '0 : pos_row + 1'b1;
      end else begin
        col_d = pos_col + 1'b1;
        row_d = pos_row;
      end
    end
  end

  // Instance k holds the line k+1 back; each feeds its output into the next.
  for (genvar k = 0; k < NLB; k++) begin : g_lb
    if (k == 0) begin : g_first
      assign lb_din[k] = in_data;
    end else begin : g_chain
      assign lb_din[k] = lb_dout[k-1];
    end

    line_buffer #(
      .DEPTH(IMAGE_WIDTH),
      .WIDTH(WORD_SIZE)
    ) u_line_buffer (
      .clk   (clk),
      .en_i  (in_valid),
      .addr_i(pos_col),
      .din_i (lb_din[k]),
      .dout_o(lb_dout[k])
    );
  end

  always_comb begin
    win_d = win_q;
    for (int unsigned r = 0; r < KERNEL_SIZE; r++) begin
      for (int unsigned c = 0; c + 1 < KERNEL_SIZE; c++) begin
        win_d[r][c] = win_q[r][c+1];
      end
    end
    for (int unsigned k = 0; k < NLB; k++) begin
      win_d[NLB-1-k][KERNEL_SIZE-1] = lb_dout[k];
    end
    win_d[KERNEL_SIZE-1][KERNEL_SIZE-1] = in_data;

    valid_d = in_valid && pos_in_window(32'(pos_row), 32'(pos_col), KERNEL_SIZE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      col_q     <= '0;
      row_q     <= '0;
      win_q     <= '0;
      valid_q   <= 1'b0;
      out_row_q <= '0;
      out_col_q <= '0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      if (in_valid) begin
        win_q     <= win_d;
        out_row_q <= pos_row;
        out_col_q <= pos_col;
      end
    end
  end

  assign window       = win_q;
  assign window_valid = valid_q;
  assign out_row      = out_row_q;
  assign out_col      = out_col_q;

endmodule
